image_conv3x3_stream: RTL and testbench
=======================================

# image_conv3x3_stream

Streaming 3x3 neighbourhood processor for the image pipeline: accepts one RGB888 pixel per handshake in raster order, converts it to 8-bit luma, and emits one processed pixel per output handshake (grayscale, Gaussian blur or Sobel magnitude, selected per frame). Two luma line buffers replace whole-frame storage and padded-frame copies; borders use a programmable pad value. The block sits between the frame source and the BMP writer, and drives `HSYNC`/`ctrl_done` exactly as the writer expects.

## Interface
- `WIDTH`, 300, pixels per line; must be at least 2.
- `HEIGHT`, 400, lines per frame; must be at least 2.
- `PAD_VALUE`, 100, 8-bit luma used for every out-of-image window tap.
- `HCLK` in 1: the single clock, rising edge.
- `HRESETn` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle frame-start pulse; sampled only in IDLE.
- `mode` in 2: 0/3 grayscale, 1 Gaussian, 2 Sobel; captured on the `start` cycle and held for the frame.
- `in_valid` in 1, `in_ready` out 1: input handshake.
- `in_R`, `in_G`, `in_B` in 8 each: input pixel.
- `out_valid` out 1, `out_ready` in 1: output handshake.
- `DATA_R`, `DATA_G`, `DATA_B` out 8 each: output pixel; all three carry the same value.
- `HSYNC` out 1: equals `out_valid`.
- `ctrl_done` out 1: one-cycle pulse at end of frame.

## Operation
- Luma on entry: Y = (R+G+B)/3, 10-bit sum, truncating. Line buffers, each WIDTH x 8 bits, hold luma for the two previous lines. A 3x3 window register shifts each step.
- Indexing: pixel k = r·WIDTH+c. Output (r,c) requires input k = (r+1)·WIDTH+(c+1). Taps with a row outside 0..HEIGHT-1 or a column outside 0..WIDTH-1 read PAD_VALUE.
- Kernels, all using window luma w[dy][dx]:
  - Grayscale: the centre tap.
  - Gaussian: kernel 1 2 1 / 2 4 2 / 1 2 1, 12-bit sum; output is (sum+8)>>4.
  - Sobel: gx = right column minus left column, weights 1,2,1; gy = bottom row minus top row, weights 1,2,1; both signed 11-bit. Output is min(255, |gx|+|gy|).
- FSM states:
  - IDLE: `start` goes to FILL. `in_ready`=0.
  - FILL: accepts WIDTH+1 pixels (k=0..WIDTH) and produces no output. It then goes to RUN.
  - RUN: `in_ready` = !out_valid || out_ready. Each accepted pixel k loads output k-(WIDTH+1) into the output register. After k = WIDTH·HEIGHT-1 is accepted, go to FLUSH.
  - FLUSH: `in_ready`=0. Produces the remaining WIDTH+1 outputs, each whenever the output register is free or being drained. Missing input taps are treated as pad. When the final output handshake completes, go to DONE.
  - DONE: `ctrl_done`=1 for one cycle, then IDLE.
- Each frame produces exactly WIDTH·HEIGHT outputs. `start` outside IDLE is ignored. Line-buffer contents are not cleared between frames; padding masks them.

## Timing
- Reset values: all outputs 0, including `in_ready`, `out_valid`, `HSYNC`, `ctrl_done` and DATA_*. State is IDLE; all counters are 0. Reset asserted mid-frame aborts the frame immediately; no `ctrl_done` follows.
- `in_ready` first rises the cycle after the `start` cycle.
- Latency: `out_valid` for output j rises the cycle after input j+WIDTH+1 is accepted (RUN), or the cycle after the slot frees (FLUSH).
- Output register: while `out_valid`=1 and `out_ready`=0, DATA_* and `out_valid` hold stable and no input is accepted. A transfer on the same cycle that a new value is loaded is allowed (full throughput, one pixel/cycle).
- `out_valid` drops the cycle after the last transfer if no new value is loaded. `ctrl_done` is high the cycle after the final output transfer, and `out_valid` is 0 in that cycle.
- Counters: column counter of $clog2(WIDTH) bits wraps at WIDTH-1; row counter of $clog2(HEIGHT+1) bits.

## Test plan
- WIDTH=4, HEIGHT=3, PAD=100, Gaussian, all pixels R=G=B=100, `out_ready`=1 -> 12 outputs, all 100; first `out_valid` the cycle after the 6th input; exactly one `ctrl_done`.
- Grayscale, pixel R=30, G=60, B=91 -> output 60; PAD irrelevant.
- Gaussian, PAD=0, all zero except luma 255 at (1,1) -> output(1,1)=64, output(1,0)=32, output(0,0)=16, output(2,3)=0.
- Sobel, PAD=0, WIDTH=4, columns 0-1 luma 0 and columns 2-3 luma 200 -> outputs (1,1) and (1,2) = 255; output (1,0)=0. Sobel on a flat 100 image with PAD=100 -> all 0.
- Backpressure: `out_ready` random 50%, 4x3 ramp image -> output sequence identical to the `out_ready`=1 run; DATA_* stable during stalls; no input accepted while stalled.
- Reset asserted after 5 inputs -> all outputs 0 and state IDLE next cycle, no `ctrl_done`; a subsequent `start` plus a full frame gives the correct 12 outputs.

Source files
------------

// File: rtl/image_conv3x3_stream.sv
// Streaming 3x3 luma filter (grayscale / Gaussian / Sobel) between the frame source and
// the BMP writer. Two luma line buffers plus a two-column window; borders read PAD_VALUE.
module image_conv3x3_stream #(
    parameter int         WIDTH     = 300,
    parameter int         HEIGHT    = 400,
    parameter logic [7:0] PAD_VALUE = 8'd100
) (
    input  logic       HCLK,
    input  logic       HRESETn,
    input  logic       start,
    input  logic [1:0] mode,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_R,
    input  logic [7:0] in_G,
    input  logic [7:0] in_B,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] DATA_R,
    output logic [7:0] DATA_G,
    output logic [7:0] DATA_B,
    output logic       HSYNC,
    output logic       ctrl_done
);

    localparam int CW = $clog2(WIDTH);
    localparam int RW = $clog2(HEIGHT + 1);
    localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);

    typedef enum logic [2:0] {S_IDLE, S_FILL, S_RUN, S_FLUSH, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [1:0]      mode_q, mode_d;
    logic [CW-1:0]   col_q, col_d, ocol_q, ocol_d;
    logic [RW-1:0]   row_q, row_d, orow_q, orow_d;
    logic            last_q, last_d;
    logic            out_valid_q, out_valid_d;
    logic [7:0]      data_q, data_d;
    logic [2:0][7:0] wl_q, wl_d, wc_q, wc_d;

    logic [7:0] lb0_mem [WIDTH];
    logic [7:0] lb1_mem [WIDTH];
    logic [7:0] lb0_rd_q, lb1_rd_q;

    logic            slot_free, step, produce;
    logic [9:0]      sum_rgb;
    logic [7:0]      y;
    logic [2:0][7:0] ncol;
    logic [8:0][7:0] tap;
    logic [2:0]      row_ok, col_ok;
    logic [11:0]     gsum;
    logic [7:0]      gauss, sobel, result;
    logic [9:0]      col_r, col_l, row_b, row_t, abs_x, abs_y;
    logic signed [10:0] gx, gy;
    logic [10:0]     mag;

    assign sum_rgb = 10'(in_R) + 10'(in_G) + 10'(in_B);
    assign y       = 8'(sum_rgb / 10'd3);
    // Right-hand window column: two buffered rows above plus the incoming pixel.
    assign ncol    = {y, lb1_rd_q, lb0_rd_q};

    assign slot_free = !out_valid_q || out_ready;

    always_comb begin
        step    = 1'b0;
        produce = 1'b0;
        if (state_q == S_FLUSH) begin
            step = slot_free && !last_q;
        end else begin
            step = in_valid && in_ready;
        end
        produce = step && (state_q == S_RUN || state_q == S_FLUSH);
    end

    // Masking by output coordinate also hides row/column wrap and stale line-buffer data.
    assign row_ok = {orow_q != ROW_LAST, 1'b1, orow_q != '0};
    assign col_ok = {ocol_q != COL_LAST, 1'b1, ocol_q != '0};

    for (genvar gi = 0; gi < 9; gi++) begin : g_tap
        localparam int DY = gi / 3;
        localparam int DX = gi % 3;
        logic [7:0] raw;
        if (DX == 0) begin : g_left
            assign raw = wl_q[DY];
        end else if (DX == 1) begin : g_centre
            assign raw = wc_q[DY];
        end else begin : g_right
            assign raw = ncol[DY];
        end
        assign tap[gi] = (row_ok[DY] && col_ok[DX]) ? raw : PAD_VALUE;
    end

    always_comb begin
        gsum  = 12'(tap[0]) + 12'(tap[2]) + 12'(tap[6]) + 12'(tap[8])
              + {3'b0, tap[1], 1'b0} + {3'b0, tap[3], 1'b0}
              + {3'b0, tap[5], 1'b0} + {3'b0, tap[7], 1'b0}
              + {2'b0, tap[4], 2'b0};
        gauss = 8'((gsum + 12'd8) >> 4);
        col_r = 10'(tap[2]) + {1'b0, tap[5], 1'b0} + 10'(tap[8]);
        col_l = 10'(tap[0]) + {1'b0, tap[3], 1'b0} + 10'(tap[6]);
        row_b = 10'(tap[6]) + {1'b0, tap[7], 1'b0} + 10'(tap[8]);
        row_t = 10'(tap[0]) + {1'b0, tap[1], 1'b0} + 10'(tap[2]);
        gx    = $signed({1'b0, col_r}) - $signed({1'b0, col_l});
        gy    = $signed({1'b0, row_b}) - $signed({1'b0, row_t});
        abs_x = gx[10] ? 10'(-gx) : 10'(gx);
        abs_y = gy[10] ? 10'(-gy) : 10'(gy);
        mag   = 11'(abs_x) + 11'(abs_y);
        sobel = (mag > 11'd255) ? 8'hFF : mag[7:0];
        case (mode_q)
            2'd1:    result = gauss;
            2'd2:    result = sobel;
            default: result = tap[4];
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q     <= S_IDLE;
            mode_q      <= '0;
            col_q       <= '0;
            row_q       <= '0;
            ocol_q      <= '0;
            orow_q      <= '0;
            last_q      <= 1'b0;
            out_valid_q <= 1'b0;
            data_q      <= '0;
            wl_q        <= '0;
            wc_q        <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            col_q       <= col_d;
            row_q       <= row_d;
            ocol_q      <= ocol_d;
            orow_q      <= orow_d;
            last_q      <= last_d;
            out_valid_q <= out_valid_d;
            data_q      <= data_d;
            wl_q        <= wl_d;
            wc_q        <= wc_d;
        end
    end

    // Read address runs one step ahead so the registered read is ready when the step fires.
    always_ff @(posedge HCLK) begin
        if (step) begin
            lb0_mem[col_q] <= lb1_rd_q;
            lb1_mem[col_q] <= y;
        end
        lb0_rd_q <= lb0_mem[col_d];
        lb1_rd_q <= lb1_mem[col_d];
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_FILL;
            S_FILL:  if (step && row_q == RW'(1) && col_q == '0) state_d = S_RUN;
            S_RUN:   if (step && row_q == ROW_LAST && col_q == COL_LAST) state_d = S_FLUSH;
            S_FLUSH: if (out_valid_q && out_ready && last_q) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mode_d      = mode_q;
        col_d       = col_q;
        row_d       = row_q;
        ocol_d      = ocol_q;
        orow_d      = orow_q;
        last_d      = last_q;
        wl_d        = wl_q;
        wc_d        = wc_q;
        out_valid_d = out_valid_q;
        data_d      = data_q;
        if (state_q == S_IDLE && start) begin
            mode_d = mode;
            col_d  = '0;
            row_d  = '0;
            ocol_d = '0;
            orow_d = '0;
            last_d = 1'b0;
        end
        if (step) begin
            wl_d = wc_q;
            wc_d = ncol;
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
        if (produce) begin
            out_valid_d = 1'b1;
            data_d      = result;
            last_d      = (orow_q == ROW_LAST) && (ocol_q == COL_LAST);
            if (ocol_q == COL_LAST) begin
                ocol_d = '0;
                orow_d = orow_q + RW'(1);
            end else begin
                ocol_d = ocol_q + CW'(1);
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_comb begin
        in_ready  = (state_q == S_FILL) || (state_q == S_RUN && slot_free);
        out_valid = out_valid_q;
        HSYNC     = out_valid_q;
        DATA_R    = data_q;
        DATA_G    = data_q;
        DATA_B    = data_q;
        ctrl_done = (state_q == S_DONE);
    end

endmodule

// File: tb/tb_image_conv3x3_stream.sv
// Directed bench for image_conv3x3_stream on a 4x3 frame; two instances (pad 100 / pad 0)
// share all inputs and the bench checks whichever one the current frame selects.
`timescale 1ns/1ps
module tb_image_conv3x3_stream;

    localparam int W = 4;
    localparam int H = 3;
    localparam int N = W * H;

    logic       HCLK = 1'b0;
    logic       HRESETn = 1'b0;
    logic       start = 1'b0;
    logic [1:0] mode = 2'd0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] in_R = 8'd0, in_G = 8'd0, in_B = 8'd0;

    logic       in_ready_a, out_valid_a, hsync_a, done_a;
    logic [7:0] dr_a, dg_a, db_a;
    logic       in_ready_b, out_valid_b, hsync_b, done_b;
    logic [7:0] dr_b, dg_b, db_b;

    bit         sel_pad0 = 1'b0;
    logic       obs_in_ready, obs_valid, obs_hsync, obs_done;
    logic [23:0] obs_data;

    logic [7:0] img_r [N];
    logic [7:0] img_g [N];
    logic [7:0] img_b [N];
    int         got   [N];
    int         exp_v [N];
    int         n_checks = 0;
    int         n_errors = 0;

    always #5 HCLK = ~HCLK;

    image_conv3x3_stream #(.WIDTH(W), .HEIGHT(H), .PAD_VALUE(8'd100)) dut_pad100 (
        .HCLK(HCLK), .HRESETn(HRESETn), .start(start), .mode(mode),
        .in_valid(in_valid), .in_ready(in_ready_a),
        .in_R(in_R), .in_G(in_G), .in_B(in_B),
        .out_valid(out_valid_a), .out_ready(out_ready),
        .DATA_R(dr_a), .DATA_G(dg_a), .DATA_B(db_a),
        .HSYNC(hsync_a), .ctrl_done(done_a)
    );

    image_conv3x3_stream #(.WIDTH(W), .HEIGHT(H), .PAD_VALUE(8'd0)) dut_pad0 (
        .HCLK(HCLK), .HRESETn(HRESETn), .start(start), .mode(mode),
        .in_valid(in_valid), .in_ready(in_ready_b),
        .in_R(in_R), .in_G(in_G), .in_B(in_B),
        .out_valid(out_valid_b), .out_ready(out_ready),
        .DATA_R(dr_b), .DATA_G(dg_b), .DATA_B(db_b),
        .HSYNC(hsync_b), .ctrl_done(done_b)
    );

    assign obs_in_ready = sel_pad0 ? in_ready_b  : in_ready_a;
    assign obs_valid    = sel_pad0 ? out_valid_b : out_valid_a;
    assign obs_hsync    = sel_pad0 ? hsync_b     : hsync_a;
    assign obs_done     = sel_pad0 ? done_b      : done_a;
    assign obs_data     = sel_pad0 ? {dr_b, dg_b, db_b} : {dr_a, dg_a, db_a};

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_pix(input int k, input int r, input int g, input int b);
        img_r[k] = 8'(r);
        img_g[k] = 8'(g);
        img_b[k] = 8'(b);
    endtask

    task automatic set_flat(input int v);
        for (int k = 0; k < N; k++) set_pix(k, v, v, v);
    endtask

    task automatic set_ramp();
        for (int k = 0; k < N; k++) set_pix(k, 20 * k, 20 * k + 3, 20 * k + 6);
    endtask

    function automatic int luma_at(int r, int c, int pad);
        if (r < 0 || r >= H || c < 0 || c >= W) return pad;
        return (int'(img_r[r * W + c]) + int'(img_g[r * W + c]) + int'(img_b[r * W + c])) / 3;
    endfunction

    function automatic int model_out(int r, int c, int md, int pad);
        int t [3][3];
        int s, gx, gy, wt;
        for (int dy = 0; dy < 3; dy++)
            for (int dx = 0; dx < 3; dx++)
                t[dy][dx] = luma_at(r + dy - 1, c + dx - 1, pad);
        if (md == 1) begin
            s = 0;
            for (int dy = 0; dy < 3; dy++)
                for (int dx = 0; dx < 3; dx++)
                    s += ((dy == 1) ? 2 : 1) * ((dx == 1) ? 2 : 1) * t[dy][dx];
            return (s + 8) / 16;
        end
        if (md == 2) begin
            gx = 0;
            gy = 0;
            for (int i = 0; i < 3; i++) begin
                wt = (i == 1) ? 2 : 1;
                gx += wt * (t[i][2] - t[i][0]);
                gy += wt * (t[2][i] - t[0][i]);
            end
            s = ((gx < 0) ? -gx : gx) + ((gy < 0) ? -gy : gy);
            return (s > 255) ? 255 : s;
        end
        return t[1][1];
    endfunction

    task automatic run_frame(input string name, input logic [1:0] md, input bit pad0, input bit bp);
        int n_in, n_out, n_done, first_nin, e;
        bit prev_stall;
        logic [23:0] prev_data;
        n_in = 0; n_out = 0; n_done = 0; first_nin = -1;
        prev_stall = 1'b0; prev_data = '0;
        sel_pad0 = pad0;
        for (int j = 0; j < N; j++) exp_v[j] = model_out(j / W, j % W, md, pad0 ? 0 : 100);
        @(negedge HCLK);
        mode = md; start = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        #1 check_eq({name, "/in_ready_idle"}, int'(obs_in_ready), 0);
        @(negedge HCLK);
        start = 1'b0;
        mode = ~md;
        for (int cyc = 0; cyc < 400 && n_done == 0; cyc++) begin
            out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (n_in < N) begin
                in_valid = 1'b1;
                in_R = img_r[n_in]; in_G = img_g[n_in]; in_B = img_b[n_in];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (cyc == 0) check_eq({name, "/in_ready_after_start"}, int'(obs_in_ready), 1);
            if (prev_stall) begin
                check_eq({name, "/stall_valid_held"}, int'(obs_valid), 1);
                check_eq({name, "/stall_data_held"}, int'(obs_data), int'(prev_data));
            end
            if (obs_valid && !out_ready) check_eq({name, "/stall_no_accept"}, int'(obs_in_ready), 0);
            if (obs_valid && first_nin < 0) first_nin = n_in;
            if (obs_valid && out_ready) begin
                check_eq({name, "/hsync"}, int'(obs_hsync), 1);
                if (n_out < N) begin
                    e = exp_v[n_out];
                    check_eq($sformatf("%s/data%0d", name, n_out), int'(obs_data), e * 32'h010101);
                    got[n_out] = int'(obs_data[7:0]);
                end
                n_out++;
            end
            if (obs_done) begin
                n_done++;
                check_eq({name, "/valid_low_at_done"}, int'(obs_valid), 0);
                check_eq({name, "/outputs_at_done"}, n_out, N);
            end
            prev_stall = obs_valid && !out_ready;
            prev_data  = obs_data;
            if (in_valid && obs_in_ready) n_in++;
            @(negedge HCLK);
        end
        in_valid = 1'b0;
        repeat (4) begin
            #1 if (obs_done) n_done++;
            @(negedge HCLK);
        end
        check_eq({name, "/done_pulses"}, n_done, 1);
        check_eq({name, "/outputs"}, n_out, N);
        if (!bp) check_eq({name, "/first_valid_after_inputs"}, first_nin, W + 2);
        $display("frame %s: mode=%0d pad=%0d inputs=%0d outputs=%0d", name, md, pad0 ? 0 : 100, n_in, n_out);
    endtask

    task automatic abort_frame();
        int n_in;
        n_in = 0;
        sel_pad0 = 1'b0;
        set_ramp();
        @(negedge HCLK);
        mode = 2'd1; start = 1'b1; out_ready = 1'b1;
        @(negedge HCLK);
        start = 1'b0;
        for (int cyc = 0; cyc < 50 && n_in < 5; cyc++) begin
            in_valid = 1'b1;
            in_R = img_r[n_in]; in_G = img_g[n_in]; in_B = img_b[n_in];
            #1 if (obs_in_ready) n_in++;
            @(negedge HCLK);
        end
        in_valid = 1'b0;
        check_eq("abort/inputs_accepted", n_in, 5);
        #1 check_eq("abort/in_ready_before_reset", int'(obs_in_ready), 1);
        #1 HRESETn = 1'b0;
        #1;
        check_eq("abort/in_ready", int'(obs_in_ready), 0);
        check_eq("abort/out_valid", int'(obs_valid), 0);
        check_eq("abort/hsync", int'(obs_hsync), 0);
        check_eq("abort/ctrl_done", int'(obs_done), 0);
        check_eq("abort/data", int'(obs_data), 0);
        @(negedge HCLK);
        HRESETn = 1'b1;
        repeat (8) begin
            #1;
            check_eq("abort/no_done", int'(obs_done), 0);
            check_eq("abort/idle_in_ready", int'(obs_in_ready), 0);
            @(negedge HCLK);
        end
        $display("frame abort: inputs=%0d then reset", n_in);
    endtask

    initial begin
        repeat (2) @(negedge HCLK);
        #1;
        check_eq("reset/in_ready", int'(obs_in_ready), 0);
        check_eq("reset/out_valid", int'(obs_valid), 0);
        check_eq("reset/hsync", int'(obs_hsync), 0);
        check_eq("reset/ctrl_done", int'(obs_done), 0);
        check_eq("reset/data", int'(obs_data), 0);
        HRESETn = 1'b1;

        set_flat(100);
        run_frame("flat_gauss", 2'd1, 1'b0, 1'b0);

        set_ramp();
        set_pix(9, 30, 60, 91);
        run_frame("gray", 2'd0, 1'b0, 1'b0);
        check_eq("gray/hand_px21", got[9], 60);

        set_flat(0);
        set_pix(5, 255, 255, 255);
        run_frame("impulse", 2'd1, 1'b1, 1'b0);
        check_eq("impulse/hand_11", got[5], 64);
        check_eq("impulse/hand_10", got[4], 32);
        check_eq("impulse/hand_00", got[0], 16);
        check_eq("impulse/hand_23", got[11], 0);

        for (int k = 0; k < N; k++) set_pix(k, (k % W >= 2) ? 200 : 0, (k % W >= 2) ? 200 : 0, (k % W >= 2) ? 200 : 0);
        run_frame("sobel_edge", 2'd2, 1'b1, 1'b0);
        check_eq("sobel_edge/hand_11", got[5], 255);
        check_eq("sobel_edge/hand_12", got[6], 255);
        check_eq("sobel_edge/hand_10", got[4], 0);

        set_flat(100);
        run_frame("sobel_flat", 2'd2, 1'b0, 1'b0);
        check_eq("sobel_flat/hand_00", got[0], 0);

        set_ramp();
        run_frame("ramp_gauss", 2'd1, 1'b0, 1'b0);
        run_frame("ramp_gauss_bp", 2'd1, 1'b0, 1'b1);
        run_frame("ramp_sobel_bp", 2'd2, 1'b1, 1'b1);

        abort_frame();
        set_ramp();
        run_frame("after_reset", 2'd2, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
